// File: rtl/v_fifo_streamer_if.sv
`timescale 1ns/1ps
// Chunk stream from the vector FIFO streamer to the MAC/dot-product stage.
// The master drives the chunk and its position flags; the slave drives ready.
interface v_fifo_streamer_if #(
    parameter int DW = 32
) ();
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last_chunk;
    logic          m_last_rep;

    modport master (
        output m_valid,
        output m_data,
        output m_last_chunk,
        output m_last_rep,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_last_chunk,
        input  m_last_rep,
        output m_ready
    );
endinterface

// File: rtl/v_fifo_streamer.sv
`timescale 1ns/1ps
// Read-side controller for the vector FIFO: replays each resident vector Repeats times
// as ElementsPerRead-wide chunks, steering the FIFO read pointer with advance/rewind strobes.
module v_fifo_streamer #(
    parameter int VecElements     = 16,
    parameter int ElementsPerRead = 4,
    parameter int NBits           = 8,
    parameter int Repeats         = 3,
    parameter int Depth           = 4
) (
    input  logic                                 clk_in,
    input  logic                                 rst_in,
    input  logic                                 vec_wr_done,
    output logic                                 fifo_rd_en,
    output logic                                 fifo_wrap_rd,
    input  logic [ElementsPerRead*NBits-1:0]     fifo_rd_data,
    v_fifo_streamer_if.master                    strm,
    output logic [$clog2(Depth+1)-1:0]           avail,
    output logic                                 overflow
);
    localparam int C  = VecElements / ElementsPerRead;
    localparam int CW = (C > 1) ? $clog2(C) : 1;
    localparam int RW = (Repeats > 1) ? $clog2(Repeats) : 1;
    localparam int AW = $clog2(Depth + 1);

    localparam logic [CW-1:0] CLAST = CW'(C - 1);
    localparam logic [RW-1:0] RLAST = RW'(Repeats - 1);
    localparam logic [AW-1:0] AMAX  = AW'(Depth);

    typedef enum logic {IDLE, STREAM} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   chunk_q, chunk_d;
    logic [RW-1:0]   rep_q, rep_d;
    logic [AW-1:0]   avail_q, avail_d;
    logic            ovf_q, ovf_d;

    logic            valid, last_chunk, last_rep, hs, consume;

    // State register
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state: enter STREAM on the same edge that makes avail non-zero,
    // so a write-done pulse in IDLE yields m_valid on the very next cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (avail_d != '0)            state_d = STREAM;
            STREAM:  if (consume && avail_d == '0) state_d = IDLE;
            default:                               state_d = IDLE;
        endcase
    end

    // Outputs and the handshake-qualified pointer strobes
    always_comb begin
        valid      = (state_q == STREAM);
        last_chunk = valid && (chunk_q == CLAST);
        last_rep   = valid && (rep_q == RLAST);
        hs         = valid && strm.m_ready;
        fifo_rd_en   = hs && (!last_chunk || last_rep);
        fifo_wrap_rd = hs && last_chunk && !last_rep;
        consume      = hs && last_chunk && last_rep;
    end

    always_comb begin
        chunk_d = chunk_q;
        rep_d   = rep_q;
        if (hs) begin
            if (!last_chunk) begin
                chunk_d = chunk_q + CW'(1);
            end else begin
                chunk_d = '0;
                rep_d   = last_rep ? '0 : rep_q + RW'(1);
            end
        end
    end

    // Availability saturates at Depth; a write into a full FIFO only raises the sticky flag.
    always_comb begin
        avail_d = avail_q;
        ovf_d   = ovf_q;
        unique case ({vec_wr_done, consume})
            2'b10: begin
                if (avail_q == AMAX) ovf_d   = 1'b1;
                else                 avail_d = avail_q + AW'(1);
            end
            2'b01:   avail_d = avail_q - AW'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            chunk_q <= '0;
            rep_q   <= '0;
            avail_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            chunk_q <= chunk_d;
            rep_q   <= rep_d;
            avail_q <= avail_d;
            ovf_q   <= ovf_d;
        end
    end

    assign strm.m_valid      = valid;
    assign strm.m_data       = fifo_rd_data;
    assign strm.m_last_chunk = last_chunk;
    assign strm.m_last_rep   = last_rep;
    assign avail             = avail_q;
    assign overflow          = ovf_q;
endmodule

// File: tb/tb_v_fifo_streamer.sv
`timescale 1ns/1ps
// Bench for v_fifo_streamer: a behavioural FIFO plus an expected-beat queue built
// from the replay rules, with randomized backpressure and write-done traffic.
module tb_v_fifo_streamer;
    localparam int VE   = 16;
    localparam int EPR  = 4;
    localparam int NB   = 8;
    localparam int REP  = 3;
    localparam int DEP  = 4;
    localparam int C    = VE / EPR;
    localparam int DW   = EPR * NB;
    localparam int MEMN = VE * DEP;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic          vec_wr_done = 1'b0;
    logic          fifo_rd_en, fifo_wrap_rd;
    logic [DW-1:0] fifo_rd_data;
    logic [2:0]    avail;
    logic          overflow;

    v_fifo_streamer_if #(.DW(DW)) sif ();

    v_fifo_streamer #(
        .VecElements(VE), .ElementsPerRead(EPR), .NBits(NB), .Repeats(REP), .Depth(DEP)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .vec_wr_done  (vec_wr_done),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_wrap_rd (fifo_wrap_rd),
        .fifo_rd_data (fifo_rd_data),
        .strm         (sif),
        .avail        (avail),
        .overflow     (overflow)
    );

    always #5 clk_in = ~clk_in;

    // Behavioural vector FIFO: circular element store with a read pointer in elements
    logic [NB-1:0] mem [MEMN];
    int rp;
    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)           rp <= 0;
        else if (fifo_rd_en)   rp <= (rp + EPR) % MEMN;
        else if (fifo_wrap_rd) rp <= (rp + MEMN - (VE - EPR)) % MEMN;
    end
    always_comb begin
        fifo_rd_data = '0;
        for (int k = 0; k < EPR; k++) fifo_rd_data[k*NB +: NB] = mem[(rp + k) % MEMN];
    end

    typedef struct packed {
        logic [DW-1:0] data;
        logic          lc;
        logic          lr;
        logic          rd;
        logic          wr;
    } beat_t;

    beat_t exp_q[$];
    int    avail_m, wp;
    bit    ovf_m, chk_en;
    int    n_chk, n_pass;
    int    cyc_n, vcyc, vfirst, vlast;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Store one vector in the FIFO and append its Repeats x C expected beats.
    task automatic push_vector(input bit seq);
        logic [NB-1:0] v [VE];
        beat_t b;
        for (int i = 0; i < VE; i++) begin
            v[i] = seq ? NB'(i) : NB'($urandom);
            mem[wp*VE + i] = v[i];
        end
        wp = (wp + 1) % DEP;
        for (int r = 0; r < REP; r++)
            for (int c = 0; c < C; c++) begin
                for (int k = 0; k < EPR; k++) b.data[k*NB +: NB] = v[c*EPR + k];
                b.lc = (c == C - 1);
                b.lr = (r == REP - 1);
                b.rd = (c < C - 1) || (r == REP - 1);
                b.wr = !b.rd;
                exp_q.push_back(b);
            end
    endtask

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic pulse(input bit seq);
        if (avail_m < DEP) push_vector(seq);
        vec_wr_done = 1'b1;
        cyc();
        vec_wr_done = 1'b0;
    endtask

    task automatic start_phase();
        vcyc = 0; vfirst = -1; vlast = -1;
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while ((avail_m != 0 || exp_q.size() != 0) && n < maxc) begin
            cyc();
            n++;
        end
        if (n >= maxc) check("drain_timeout", 64'(n), 64'(0));
        repeat (3) cyc();
    endtask

    // Monitor: compare at the falling edge, advance the model at the rising edge
    always begin
        bit    hs, cons, apply;
        beat_t e;
        int    nxt_a;
        bit    nxt_o;
        @(negedge clk_in);
        cyc_n++;
        apply = 1'b0;
        cons  = 1'b0;
        if (chk_en) begin
            apply = 1'b1;
            check("valid", 64'(sif.m_valid), 64'(avail_m != 0));
            check("avail", 64'(avail), 64'(avail_m));
            check("overflow", 64'(overflow), 64'(ovf_m));
            hs = sif.m_valid && sif.m_ready;
            if (sif.m_valid) begin
                vcyc++;
                if (vfirst < 0) vfirst = cyc_n;
                vlast = cyc_n;
            end
            if (hs) begin
                if (exp_q.size() == 0) begin
                    check("beat_unexpected", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("data", 64'(sif.m_data), 64'(e.data));
                    check("last_chunk", 64'(sif.m_last_chunk), 64'(e.lc));
                    check("last_rep", 64'(sif.m_last_rep), 64'(e.lr));
                    check("rd_en", 64'(fifo_rd_en), 64'(e.rd));
                    check("wrap_rd", 64'(fifo_wrap_rd), 64'(e.wr));
                    cons = e.lc && e.lr;
                end
            end else begin
                check("rd_en_idle", 64'(fifo_rd_en), 64'(0));
                check("wrap_idle", 64'(fifo_wrap_rd), 64'(0));
                if (sif.m_valid && exp_q.size() != 0) begin
                    check("stall_data", 64'(sif.m_data), 64'(exp_q[0].data));
                    check("stall_last_chunk", 64'(sif.m_last_chunk), 64'(exp_q[0].lc));
                    check("stall_last_rep", 64'(sif.m_last_rep), 64'(exp_q[0].lr));
                end
            end
            nxt_a = avail_m;
            nxt_o = ovf_m;
            if (vec_wr_done && !cons) begin
                if (avail_m == DEP) nxt_o = 1'b1;
                else                nxt_a = avail_m + 1;
            end else if (!vec_wr_done && cons) begin
                nxt_a = avail_m - 1;
            end
        end
        @(posedge clk_in);
        if (apply && chk_en) begin
            avail_m = nxt_a;
            ovf_m   = nxt_o;
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_chk = 0; n_pass = 0; cyc_n = 0;
        avail_m = 0; ovf_m = 1'b0; wp = 0; chk_en = 1'b0;
        sif.m_ready = 1'b0;
        start_phase();
        #2;
        check("rst_valid", 64'(sif.m_valid), 64'(0));
        check("rst_rd_en", 64'(fifo_rd_en), 64'(0));
        check("rst_wrap", 64'(fifo_wrap_rd), 64'(0));
        check("rst_avail", 64'(avail), 64'(0));
        check("rst_overflow", 64'(overflow), 64'(0));
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b1;
        chk_en = 1'b1;
        repeat (4) cyc();

        // Single vector 0..15, always ready
        sif.m_ready = 1'b1;
        start_phase();
        pulse(1'b1);
        drain(100);
        check("single_vcyc", 64'(vcyc), 64'(12));
        check("single_span", 64'(vlast - vfirst + 1), 64'(12));

        // Backpressure: ready alternates starting low on the first valid cycle
        begin
            bit rdy;
            int n;
            sif.m_ready = 1'b0;
            start_phase();
            pulse(1'b1);
            rdy = 1'b0;
            n = 0;
            while (avail_m != 0 && n < 60) begin
                sif.m_ready = rdy;
                cyc();
                rdy = !rdy;
                n++;
            end
            sif.m_ready = 1'b1;
            drain(20);
            check("bp_vcyc", 64'(vcyc), 64'(24));
        end

        // Back-to-back vectors
        start_phase();
        pulse(1'b0);
        pulse(1'b0);
        drain(100);
        check("b2b_vcyc", 64'(vcyc), 64'(24));
        check("b2b_span", 64'(vlast - vfirst + 1), 64'(24));

        // Write-done coincident with the consuming handshake of vector 1
        start_phase();
        pulse(1'b0);
        repeat (11) cyc();
        pulse(1'b0);
        check("coinc_avail", 64'(avail), 64'(1));
        drain(100);
        check("coinc_span", 64'(vlast - vfirst + 1), 64'(24));
        check("coinc_vcyc", 64'(vcyc), 64'(24));

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            sif.m_ready = ($urandom_range(0, 3) != 0);
            if (avail_m < DEP && $urandom_range(0, 9) == 0) pulse(1'b0);
            else cyc();
        end
        sif.m_ready = 1'b1;
        drain(400);

        // Overflow with the consumer stalled
        sif.m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pulse(1'b0);
            if (i == 3) begin
                check("ovf_avail4", 64'(avail), 64'(4));
                check("ovf_flag_before", 64'(overflow), 64'(0));
            end
        end
        check("ovf_avail_sat", 64'(avail), 64'(4));
        check("ovf_flag", 64'(overflow), 64'(1));
        sif.m_ready = 1'b1;
        repeat (20) cyc();
        check("ovf_sticky", 64'(overflow), 64'(1));

        // Asynchronous reset mid-cycle while streaming
        @(posedge clk_in);
        #3;
        rst_in = 1'b0;
        chk_en = 1'b0;
        #1;
        check("arst_valid", 64'(sif.m_valid), 64'(0));
        check("arst_rd_en", 64'(fifo_rd_en), 64'(0));
        check("arst_wrap", 64'(fifo_wrap_rd), 64'(0));
        check("arst_avail", 64'(avail), 64'(0));
        check("arst_overflow", 64'(overflow), 64'(0));
        exp_q.delete();
        avail_m = 0; ovf_m = 1'b0; wp = 0;
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b1;
        chk_en = 1'b1;
        repeat (5) cyc();
        start_phase();
        pulse(1'b1);
        drain(100);
        check("post_rst_vcyc", 64'(vcyc), 64'(12));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
